uart_cmd_framer: RTL and testbench
==================================

UART_CMD_FRAMER -- requirements
Module: uart_cmd_framer

Interface
REQ-001 Parameter CMD_BYTES, 2, bytes per inbound command (legal range 1..8).
REQ-002 Parameter RESP_BYTES, 1, bytes per outbound response (legal range 1..8).
REQ-003 Parameter TIMEOUT_CYC, 65536, max clk cycles between bytes of one command; 0 disables the timeout.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 rx_rdy  in  1  UART byte-received flag.
REQ-008 rx_data  in  8  UART received byte, valid while rx_rdy=1.
REQ-009 clr_rx_rdy  out  1  combinational acknowledge to UART; consumes the byte.
REQ-010 cmd  out  8*CMD_BYTES  assembled command, first byte in the MSBs.
REQ-011 cmd_rdy  out  1  command-valid flag, sticky.
REQ-012 clr_cmd_rdy  in  1  consumer clear of cmd_rdy.
REQ-013 overrun  out  1  one-cycle pulse; a command completed while cmd_rdy was still set.
REQ-014 frame_err  out  1  one-cycle pulse; partial command discarded by timeout.
REQ-015 resp  in  8*RESP_BYTES  response word, first byte sent from the MSBs.
REQ-016 send_resp  in  1  one-cycle request to transmit resp.
REQ-017 trmt  out  1  one-cycle pulse to UART to start a byte.
REQ-018 tx_data  out  8  byte presented to UART.
REQ-019 tx_done  in  1  UART byte-transmitted pulse.
REQ-020 tx_busy  out  1  high while a response is being serialised.
REQ-021 resp_sent  out  1  one-cycle pulse after the last response byte completes.

Function
REQ-022 RX FSM states: R_IDLE (no bytes held) and R_COLLECT (1..CMD_BYTES-1 bytes held).
REQ-023 clr_rx_rdy shall equal rx_rdy in every state, combinationally; every byte is consumed in the cycle it is presented.
REQ-024 On each consumed byte, the byte shall shift into an internal shift register and the byte counter shall increment.
REQ-025 On the edge that consumes byte CMD_BYTES: cmd <= {held bytes, rx_data}; cmd_rdy <= 1; counter <= 0; state -> R_IDLE. cmd_rdy therefore rises 1 cycle after the final rx_rdy.
REQ-026 With CMD_BYTES=1, every byte completes a command and R_COLLECT is never entered.
REQ-027 cmd shall hold its value until the next command completes; it shall not change on partial bytes.
REQ-028 cmd_rdy shall clear on clr_cmd_rdy; if completion and clr_cmd_rdy occur in the same cycle, set wins.
REQ-029 If completion occurs while cmd_rdy=1 and clr_cmd_rdy=0, cmd is overwritten and overrun pulses 1 cycle.
REQ-030 Timeout counter: cleared on every consumed byte, increments each cycle in R_COLLECT; on reaching TIMEOUT_CYC (nonzero), held bytes are discarded, state -> R_IDLE, frame_err pulses; cmd and cmd_rdy are unchanged.
REQ-031 Timeout counter width shall be $clog2(TIMEOUT_CYC+1) and shall saturate; it shall never wrap.
REQ-032 TX FSM states: T_IDLE, T_START (trmt=1 for exactly 1 cycle), T_WAIT (await tx_done).
REQ-033 In T_IDLE, send_resp shall latch resp, zero the byte index, and go to T_START; tx_busy=1 from the next cycle.
REQ-034 send_resp while tx_busy=1 shall be ignored.
REQ-035 tx_data shall be byte[index] of the latched response, MSB-first, stable from T_START until tx_done.
REQ-036 On tx_done in T_WAIT: if more bytes remain, index++ and go to T_START; otherwise go to T_IDLE, pulse resp_sent, and clear tx_busy on the same edge.
REQ-037 The RX and TX paths shall be fully independent and may operate concurrently.

Reset
REQ-038 rst=1 at a clock edge: both FSMs go idle; counters and the timeout counter are zeroed; any partial command or partial response is abandoned.
REQ-039 Reset values: cmd=0, cmd_rdy=0, overrun=0, frame_err=0, trmt=0, tx_data=0, tx_busy=0, resp_sent=0.

Verification
REQ-040 CMD_BYTES=2: bytes 0xA5, 0x3C -> cmd=0xA53C, cmd_rdy=1 one cycle after the 2nd rx_rdy, clr_rx_rdy high on each rx_rdy cycle.
REQ-041 CMD_BYTES=3, TIMEOUT_CYC=50: byte 0x11, then 50 idle cycles -> frame_err pulse; then 0x22, 0x33, 0x44 -> cmd=0x223344.
REQ-042 Two commands 0x0102, 0x0304 with no clr_cmd_rdy -> overrun pulse, cmd=0x0304; clr_cmd_rdy on the completion cycle -> cmd_rdy stays 1.
REQ-043 RESP_BYTES=2, resp=0xBEEF, send_resp -> trmt with tx_data=0xBE, after tx_done trmt with tx_data=0xEF, after tx_done resp_sent pulse; a second send_resp mid-response is ignored.
REQ-044 rst asserted after the 1st of 2 command bytes and during a TX byte -> all outputs at reset values; the next 2 bytes 0x55, 0xAA give cmd=0x55AA.

Source files
------------

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
//   Collects fixed-length commands from a byte-wide UART receiver and
//   serialises fixed-length responses to a byte-wide UART transmitter.
//   The receive and transmit paths share only the clock and reset.
//
// Parameters
//   CMD_BYTES   bytes per inbound command (1..8)
//   RESP_BYTES  bytes per outbound response (1..8)
//   TIMEOUT_CYC max idle cycles between bytes of one command, 0 = no timeout
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   rx_rdy        receiver has a byte on rx_data
//   rx_data       received byte
//   clr_rx_rdy    acknowledge to receiver (combinational copy of rx_rdy)
//   cmd           last completed command, first byte in the MSBs
//   cmd_rdy       sticky command-valid flag
//   clr_cmd_rdy   consumer clear of cmd_rdy
//   overrun       pulse: command completed while cmd_rdy was still set
//   frame_err     pulse: partial command dropped after inter-byte timeout
//   resp          response word, first byte in the MSBs
//   send_resp     request to transmit resp (ignored while tx_busy)
//   trmt          pulse: start transmitting tx_data
//   tx_data       byte presented to the transmitter
//   tx_done       transmitter finished the current byte
//   tx_busy       high while a response is being serialised
//   resp_sent     pulse: last response byte completed
module uart_cmd_framer #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    overrun,
  output logic                    frame_err,
  input  logic [8*RESP_BYTES-1:0] resp,
  input  logic                    send_resp,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic                    tx_busy,
  output logic                    resp_sent
);

  localparam int CMD_W  = 8 * CMD_BYTES;
  localparam int RESP_W = 8 * RESP_BYTES;
  localparam int CNT_W  = $clog2(CMD_BYTES + 1);
  localparam int IDX_W  = $clog2(RESP_BYTES + 1);
  // A disabled timeout still needs a legal (1-bit) counter.
  localparam int TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_CMD_IDX  = CNT_W'(CMD_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_RESP_IDX = IDX_W'(RESP_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_MAX        = TO_W'(TIMEOUT_CYC);

  typedef enum logic {
    R_IDLE,
    R_COLLECT
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_WAIT
  } tx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t          r_rx_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [CMD_W-1:0]   r_shift;
  logic [CMD_W-1:0]   r_cmd;
  logic               r_cmd_rdy;
  logic               r_overrun;
  logic               r_frame_err;

  logic [CMD_W-1:0]   w_next_shift;
  logic               w_last_byte;
  logic               w_timeout;

  // Shifting left by a whole byte also covers CMD_BYTES=1, where the
  // shifted term is simply zero.
  assign w_next_shift = (r_shift << 8) | CMD_W'(rx_data);
  assign w_last_byte  = (r_cnt == LAST_CMD_IDX);
  assign w_timeout    = (TIMEOUT_CYC != 0) && (r_to_cnt == TO_MAX);

  assign clr_rx_rdy = rx_rdy;

  // Byte shift register carries data only; stale bytes are always pushed
  // out by a full command before they can reach cmd.
  always_ff @(posedge clk) begin
    if (rx_rdy) begin
      r_shift <= w_next_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state  <= R_IDLE;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      // A completion below overrides this clear (set wins).
      if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
      if (rx_rdy) begin
        r_to_cnt <= '0;
        if (w_last_byte) begin
          r_cmd      <= w_next_shift;
          r_cmd_rdy  <= 1'b1;
          r_overrun  <= r_cmd_rdy & ~clr_cmd_rdy;
          r_cnt      <= '0;
          r_rx_state <= R_IDLE;
        end else begin
          r_cnt      <= r_cnt + CNT_W'(1);
          r_rx_state <= R_COLLECT;
        end
      end else if (r_rx_state == R_COLLECT) begin
        if (w_timeout) begin
          r_cnt       <= '0;
          r_to_cnt    <= '0;
          r_rx_state  <= R_IDLE;
          r_frame_err <= 1'b1;
        end else if (r_to_cnt != TO_MAX) begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

  // ---------------------------------------------------------------- TX path
  tx_state_t          r_tx_state;
  logic [IDX_W-1:0]   r_idx;
  logic [RESP_W-1:0]  r_resp_sh;
  logic               r_trmt;
  logic [7:0]         r_tx_data;
  logic               r_tx_busy;
  logic               r_resp_sent;

  // r_resp_sh holds the not-yet-sent bytes of the latched response,
  // next byte in the MSBs, so tx_data is always loaded from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state  <= T_IDLE;
      r_idx       <= '0;
      r_trmt      <= 1'b0;
      r_tx_data   <= '0;
      r_tx_busy   <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      r_resp_sent <= 1'b0;
      case (r_tx_state)
        T_IDLE: begin
          if (send_resp) begin
            r_resp_sh  <= resp << 8;
            r_tx_data  <= resp[RESP_W-1 -: 8];
            r_idx      <= '0;
            r_trmt     <= 1'b1;
            r_tx_busy  <= 1'b1;
            r_tx_state <= T_START;
          end
        end
        T_START: begin
          r_trmt     <= 1'b0;
          r_tx_state <= T_WAIT;
        end
        T_WAIT: begin
          if (tx_done) begin
            if (r_idx == LAST_RESP_IDX) begin
              r_tx_busy   <= 1'b0;
              r_resp_sent <= 1'b1;
              r_tx_state  <= T_IDLE;
            end else begin
              r_idx      <= r_idx + IDX_W'(1);
              r_tx_data  <= r_resp_sh[RESP_W-1 -: 8];
              r_resp_sh  <= r_resp_sh << 8;
              r_trmt     <= 1'b1;
              r_tx_state <= T_START;
            end
          end
        end
        default: begin
          r_trmt     <= 1'b0;
          r_tx_state <= T_IDLE;
        end
      endcase
    end
  end

  assign trmt      = r_trmt;
  assign tx_data   = r_tx_data;
  assign tx_busy   = r_tx_busy;
  assign resp_sent = r_resp_sent;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Testbench for uart_cmd_framer.
//   Instance A: 2-byte commands, 2-byte responses, default timeout.
//   Instance B: 3-byte commands, 1-byte responses, 50-cycle timeout.
module tb_uart_cmd_framer;

  localparam int A_CB = 2;
  localparam int A_RB = 2;
  localparam int B_CB = 3;
  localparam int B_RB = 1;
  localparam int B_TO = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic                 a_rx_rdy, a_clr_rx_rdy, a_cmd_rdy, a_clr_cmd_rdy;
  logic [7:0]           a_rx_data, a_tx_data;
  logic [8*A_CB-1:0]    a_cmd;
  logic                 a_overrun, a_frame_err, a_send_resp, a_trmt;
  logic [8*A_RB-1:0]    a_resp;
  logic                 a_tx_done, a_tx_busy, a_resp_sent;

  logic                 b_rx_rdy, b_clr_rx_rdy, b_cmd_rdy, b_clr_cmd_rdy;
  logic [7:0]           b_rx_data, b_tx_data;
  logic [8*B_CB-1:0]    b_cmd;
  logic                 b_overrun, b_frame_err, b_send_resp, b_trmt;
  logic [8*B_RB-1:0]    b_resp;
  logic                 b_tx_done, b_tx_busy, b_resp_sent;

  uart_cmd_framer #(.CMD_BYTES(A_CB), .RESP_BYTES(A_RB)) dut_a (
    .clk(clk), .rst(rst),
    .rx_rdy(a_rx_rdy), .rx_data(a_rx_data), .clr_rx_rdy(a_clr_rx_rdy),
    .cmd(a_cmd), .cmd_rdy(a_cmd_rdy), .clr_cmd_rdy(a_clr_cmd_rdy),
    .overrun(a_overrun), .frame_err(a_frame_err),
    .resp(a_resp), .send_resp(a_send_resp), .trmt(a_trmt), .tx_data(a_tx_data),
    .tx_done(a_tx_done), .tx_busy(a_tx_busy), .resp_sent(a_resp_sent)
  );

  uart_cmd_framer #(.CMD_BYTES(B_CB), .RESP_BYTES(B_RB), .TIMEOUT_CYC(B_TO)) dut_b (
    .clk(clk), .rst(rst),
    .rx_rdy(b_rx_rdy), .rx_data(b_rx_data), .clr_rx_rdy(b_clr_rx_rdy),
    .cmd(b_cmd), .cmd_rdy(b_cmd_rdy), .clr_cmd_rdy(b_clr_cmd_rdy),
    .overrun(b_overrun), .frame_err(b_frame_err),
    .resp(b_resp), .send_resp(b_send_resp), .trmt(b_trmt), .tx_data(b_tx_data),
    .tx_done(b_tx_done), .tx_busy(b_tx_busy), .resp_sent(b_resp_sent)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_byte(input logic [7:0] b, input logic clr);
    a_rx_rdy = 1'b1; a_rx_data = b; a_clr_cmd_rdy = clr;
    #1;
    chk("a_clr_rx_rdy", a_clr_rx_rdy, 1);
    step();
    a_rx_rdy = 1'b0; a_clr_cmd_rdy = 1'b0;
  endtask

  task automatic b_byte(input logic [7:0] b);
    b_rx_rdy = 1'b1; b_rx_data = b;
    #1;
    chk("b_clr_rx_rdy", b_clr_rx_rdy, 1);
    step();
    b_rx_rdy = 1'b0;
  endtask

  task automatic a_reset_values(input string tag);
    chk({tag, "_cmd"},       a_cmd, 0);
    chk({tag, "_cmd_rdy"},   a_cmd_rdy, 0);
    chk({tag, "_overrun"},   a_overrun, 0);
    chk({tag, "_frame_err"}, a_frame_err, 0);
    chk({tag, "_trmt"},      a_trmt, 0);
    chk({tag, "_tx_data"},   a_tx_data, 0);
    chk({tag, "_tx_busy"},   a_tx_busy, 0);
    chk({tag, "_resp_sent"}, a_resp_sent, 0);
  endtask

  // Reference model state for the randomized command stream on A.
  logic [7:0]        held[$];
  logic [8*A_CB-1:0] m_cmd;
  logic              m_rdy, m_ovr;
  logic [8*A_RB-1:0] m_resp;
  logic [7:0]        m_byte;

  int       gap, pulses, at;
  logic     clr;
  logic [7:0] rb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_rx_rdy = 0; a_rx_data = 0; a_clr_cmd_rdy = 0; a_resp = 0; a_send_resp = 0; a_tx_done = 0;
    b_rx_rdy = 0; b_rx_data = 0; b_clr_cmd_rdy = 0; b_resp = 8'h5A; b_send_resp = 0; b_tx_done = 0;
    step(); step();
    a_reset_values("rst0");
    chk("rst0_a_clr_rx_rdy", a_clr_rx_rdy, 0);
    chk("rst0_b_cmd", b_cmd, 0);
    chk("rst0_b_cmd_rdy", b_cmd_rdy, 0);
    chk("rst0_b_outs", {b_overrun, b_frame_err, b_trmt, b_tx_busy, b_resp_sent, b_tx_data}, 0);
    rst = 1'b0;
    step();

    // Basic two-byte command.
    a_byte(8'hA5, 0);
    chk("a5_partial_rdy", a_cmd_rdy, 0);
    chk("a5_partial_cmd", a_cmd, 0);
    a_byte(8'h3C, 0);
    chk("a53c_cmd", a_cmd, 16'hA53C);
    chk("a53c_rdy", a_cmd_rdy, 1);
    chk("a53c_ovr", a_overrun, 0);

    // Clear, then overrun, then clear coinciding with completion.
    a_clr_cmd_rdy = 1; step(); a_clr_cmd_rdy = 0;
    chk("clr_rdy", a_cmd_rdy, 0);
    a_byte(8'h01, 0);
    chk("0102_partial_cmd", a_cmd, 16'hA53C);
    a_byte(8'h02, 0);
    chk("0102_cmd", a_cmd, 16'h0102);
    chk("0102_ovr", a_overrun, 0);
    a_byte(8'h03, 0);
    a_byte(8'h04, 0);
    chk("0304_cmd", a_cmd, 16'h0304);
    chk("0304_ovr", a_overrun, 1);
    step();
    chk("ovr_pulse_end", a_overrun, 0);
    a_byte(8'h05, 0);
    a_byte(8'h06, 1);
    chk("setwins_rdy", a_cmd_rdy, 1);
    chk("setwins_cmd", a_cmd, 16'h0506);
    chk("setwins_ovr", a_overrun, 0);

    // Reset mid-command and mid-response.
    a_byte(8'h77, 0);
    a_resp = 16'hCAFE; a_send_resp = 1; step(); a_send_resp = 0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    a_reset_values("rst1");
    step(); step();
    chk("rst1_no_trmt", a_trmt, 0);
    a_byte(8'h55, 0);
    chk("55_partial_rdy", a_cmd_rdy, 0);
    a_byte(8'hAA, 0);
    chk("55aa_cmd", a_cmd, 16'h55AA);
    chk("55aa_rdy", a_cmd_rdy, 1);

    // Responses: first is 0xBEEF, then random words; random tx_done delay
    // and spurious send_resp while busy.
    for (int r = 0; r < 8; r++) begin
      m_resp = (r == 0) ? 16'hBEEF : 16'($urandom);
      a_resp = m_resp; a_send_resp = 1; step(); a_send_resp = 0;
      a_resp = 16'($urandom);
      for (int i = 0; i < A_RB; i++) begin
        m_byte = 8'(m_resp >> (8 * (A_RB - 1 - i)));
        chk("tx_trmt", a_trmt, 1);
        chk("tx_data", a_tx_data, m_byte);
        chk("tx_busy", a_tx_busy, 1);
        gap = $urandom_range(1, 4);
        for (int g = 0; g < gap; g++) begin
          a_send_resp = ($urandom_range(0, 1) == 1);
          step();
          a_send_resp = 0;
          chk("tx_trmt_low", a_trmt, 0);
          chk("tx_data_hold", a_tx_data, m_byte);
        end
        a_tx_done = 1; step(); a_tx_done = 0;
      end
      chk("tx_resp_sent", a_resp_sent, 1);
      chk("tx_busy_end", a_tx_busy, 0);
      chk("tx_no_retrigger", a_trmt, 0);
      step();
      chk("tx_resp_sent_pulse", a_resp_sent, 0);
      chk("tx_idle_trmt", a_trmt, 0);
    end

    // Randomized command stream against a queue model.
    held.delete();
    m_cmd = 16'h55AA; m_rdy = 1; m_ovr = 0;
    for (int it = 0; it < 120; it++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        clr = ($urandom_range(0, 3) == 0);
        a_clr_cmd_rdy = clr;
        if (clr) m_rdy = 0;
        m_ovr = 0;
        step();
        a_clr_cmd_rdy = 0;
        chk("rnd_idle_rdy", a_cmd_rdy, m_rdy);
        chk("rnd_idle_ovr", a_overrun, m_ovr);
      end
      rb  = 8'($urandom);
      clr = ($urandom_range(0, 3) == 0);
      held.push_back(rb);
      m_ovr = 0;
      if (held.size() == A_CB) begin
        m_cmd = '0;
        foreach (held[k]) m_cmd = (m_cmd << 8) | (8*A_CB)'(held[k]);
        m_ovr = m_rdy && !clr;
        m_rdy = 1;
        held.delete();
      end else if (clr) begin
        m_rdy = 0;
      end
      a_byte(rb, clr);
      chk("rnd_cmd", a_cmd, m_cmd);
      chk("rnd_rdy", a_cmd_rdy, m_rdy);
      chk("rnd_ovr", a_overrun, m_ovr);
      chk("rnd_ferr", a_frame_err, 0);
    end

    // Instance B: inter-byte timeout drops a partial command.
    b_byte(8'h11);
    pulses = 0; at = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (b_frame_err) begin
        pulses++;
        at = k;
      end
    end
    chk("b_ferr_pulses", pulses, 1);
    chk("b_ferr_window", (at >= B_TO - 2) && (at <= B_TO + 3), 1);
    chk("b_ferr_cmd_kept", b_cmd, 0);
    chk("b_ferr_rdy_kept", b_cmd_rdy, 0);
    b_byte(8'h22);
    b_byte(8'h33);
    chk("b_partial_rdy", b_cmd_rdy, 0);
    b_byte(8'h44);
    chk("b_223344_cmd", b_cmd, 24'h223344);
    chk("b_223344_rdy", b_cmd_rdy, 1);

    // Gaps below the timeout keep the partial command.
    pulses = 0;
    b_byte(8'h01);
    for (int k = 0; k < 40; k++) begin step(); if (b_frame_err) pulses++; end
    b_byte(8'h02);
    for (int k = 0; k < 40; k++) begin step(); if (b_frame_err) pulses++; end
    b_byte(8'h03);
    chk("b_slow_cmd", b_cmd, 24'h010203);
    chk("b_slow_ovr", b_overrun, 1);
    chk("b_slow_no_ferr", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
